// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift normalizer: FSM state encoding and the
// default data word width.
package shift_normalizer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_normalizer.sv
// Shift normalizer: accepts a word, shifts it left until its MSB is set
// (or it is all-zero), and reports the normalized word plus the number of
// positions shifted. One word is in flight at a time, using valid/ready
// handshakes on both sides.
// Optional feature: define SHIFT_NORMALIZER_ZERO_FLAG_EN to add the
// out_zero output, which flags an all-zero result while it is presented.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic workZero;
  logic workMsb;

  assign workZero = (work_q == '0);
  assign workMsb  = work_q[WIDTH-1];

  // State, working register and shift counter, cleared asynchronously so a
  // reset mid-operation throws away any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load on accept, shift one bit per cycle until
  // normalized, then hold the result until the consumer takes it.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The counter guard is redundant for legal operation (a nonzero word
        // is normalized after at most WIDTH-1 shifts) but keeps the counter
        // from ever wrapping.
        if (workMsb || workZero || (cnt_q == CNT_MAX)) begin
          state_d = DONE;
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;
  assign out_shift = cnt_q;

`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
  assign out_zero = (state_q == DONE) && workZero;
`endif

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer (WIDTH = 8): a table of directed
// vectors, randomized words checked against an arithmetic reference model,
// plus hand-written backpressure and mid-operation reset sequences.
// Compile with SHIFT_NORMALIZER_ZERO_FLAG_EN defined to also check out_zero.
module tb_shift_normalizer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_shift;
  logic             outZero;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [7:0] inData;
    logic [7:0] expData;
    int         expShift;
    int         expLatency;
    logic       expZero;
  } vector_t;

  vector_t vectors[8];

  shift_normalizer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift)
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    ,
    .out_zero  (outZero)
`endif
  );

`ifndef SHIFT_NORMALIZER_ZERO_FLAG_EN
  assign outZero = 1'b0;
`endif

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: normalization by plain arithmetic. Multiply by two
  // until the value reaches the top half of the range.
  task automatic refModel(input logic [7:0] d, output logic [7:0] nd,
                          output int sh, output int lat);
    int v;
    v  = int'(d);
    sh = 0;
    if (v == 0) begin
      nd  = 8'h00;
      lat = 1;
    end else begin
      while (v < 128) begin
        v  = v * 2;
        sh = sh + 1;
      end
      nd  = 8'(v);
      lat = sh + 1;
    end
  endtask

  // Count rising edges until out_valid is seen (0 means it never came).
  task automatic waitResult(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Offer one word, then scramble in_data after the accept edge so that any
  // late sampling of the input would corrupt the result.
  task automatic applyStimulus(input logic [7:0] d, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    waitResult(lat);
  endtask

  // Take the result with a one-edge out_ready pulse and check the return
  // to IDLE.
  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Run one word through and compare against the expected values.
  task automatic runWord(input string name, input logic [7:0] d,
                         input logic [7:0] expData, input int expShift,
                         input int expLat, input logic expZero);
    int lat;
    applyStimulus(d, lat);
    checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, "_data"}, 32'(out_data), 32'(expData));
    checkOutput({name, "_shift"}, 32'(out_shift), 32'(expShift));
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    checkOutput({name, "_zero"}, 32'(outZero), 32'(expZero));
`else
    if (expZero) begin
    end
`endif
    releaseResult(name);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] expData;
    int         expShift;
    int         expLat;
    int         lat;
    logic [7:0] heldData;
    logic [CNT_W-1:0] heldShift;

    vectors[0] = '{8'h80, 8'h80, 0, 1, 1'b0};
    vectors[1] = '{8'h01, 8'h80, 7, 8, 1'b0};
    vectors[2] = '{8'h13, 8'h98, 3, 4, 1'b0};
    vectors[3] = '{8'h00, 8'h00, 0, 1, 1'b1};
    vectors[4] = '{8'h40, 8'h80, 1, 2, 1'b0};
    vectors[5] = '{8'hFF, 8'hFF, 0, 1, 1'b0};
    vectors[6] = '{8'h02, 8'h80, 6, 7, 1'b0};
    vectors[7] = '{8'h2B, 8'hAC, 2, 3, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    #2;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_shift", 32'(out_shift), 32'd0);
`ifdef SHIFT_NORMALIZER_ZERO_FLAG_EN
    checkOutput("reset_out_zero", 32'(outZero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      runWord($sformatf("vec%0d", i), vectors[i].inData, vectors[i].expData,
              vectors[i].expShift, vectors[i].expLatency, vectors[i].expZero);
    end

    $display("[TB] randomized words");
    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      if (i % 5 == 0) rd = rd >> $urandom_range(7, 1);
      refModel(rd, expData, expShift, expLat);
      runWord($sformatf("rand%0d", i), rd, expData, expShift, expLat, rd == 8'h00);
    end

    $display("[TB] backpressure with in_valid held high");
    applyStimulus(8'h13, lat);
    checkOutput("bp_latency", 32'(lat), 32'd4);
    heldData  = out_data;
    heldShift = out_shift;
    checkOutput("bp_data", 32'(heldData), 32'h98);
    checkOutput("bp_shift", 32'(heldShift), 32'd3);
    in_valid = 1'b1;
    in_data  = 8'h05;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_data", c), 32'(out_data), 32'(heldData));
      checkOutput($sformatf("bp_hold%0d_shift", c), 32'(out_shift), 32'(heldShift));
      checkOutput($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_after_pulse_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_after_pulse_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_next_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_data  = 8'hFF;
    waitResult(lat);
    checkOutput("bp_second_latency", 32'(lat), 32'd6);
    checkOutput("bp_second_data", 32'(out_data), 32'hA0);
    checkOutput("bp_second_shift", 32'(out_shift), 32'd5);
    releaseResult("bp_second");

    $display("[TB] reset during SHIFT");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_out_data", 32'(out_data), 32'd0);
    checkOutput("mid_reset_out_shift", 32'(out_shift), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h20;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    waitResult(lat);
    checkOutput("post_reset_latency", 32'(lat), 32'd3);
    checkOutput("post_reset_data", 32'(out_data), 32'h80);
    checkOutput("post_reset_shift", 32'(out_shift), 32'd2);
    releaseResult("post_reset");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
